// File: rtl/instr_fetch_unit_pkg.sv
// Shared widths, defaults and the fetch-queue entry layout
// for the instruction fetch unit.
package instr_fetch_unit_pkg;

  localparam int PC_W      = 8;
  localparam int INSTR_W   = 32;
  localparam int PC_STEP   = 4;
  localparam int DEPTH_DEF = 4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fq_entry_t;

  function automatic logic [PC_W-1:0] pc_inc(
    input logic [PC_W-1:0] pc
  );
    return pc + PC_W'(PC_STEP);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Fetch queue: DEPTH entries of {instr, pc+4}, wrap-around pointers,
// occupancy count and a single-cycle flush.
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  fq_entry_t                  wdata,
  output fq_entry_t                  rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fq_entry_t       mem_q [DEPTH];
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // storage needs no reset: the count alone says what is live
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_q] <= wdata;
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC sequencing, epoch-tagged single-cycle memory
// requests and a decoupling queue towards decode.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int              DEPTH    = DEPTH_DEF,
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               stall,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic            epoch_q, epoch_d;
  logic            req_ep_q, req_ep_d;
  logic            outst_q, outst_d;

  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  logic            full;
  logic            push, pop;
  fq_entry_t       wdata, rdata;
  logic            unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  always_comb begin
    occ       = {1'b0, count} + (CW+1)'(outst_q);
    imem_req  = rst_n && !redirect && (occ < (CW+1)'(DEPTH));
    imem_addr = pc_q;

    // stale-epoch responses belong to a flushed stream
    push = imem_valid && outst_q && (req_ep_q == epoch_q) && !redirect;
    pop  = out_valid && !stall && !redirect;

    wdata.instr = imem_data;
    wdata.pc    = pc_inc(req_pc_q);

    pc_d     = pc_q;
    epoch_d  = epoch_q ^ redirect;
    outst_d  = imem_req;
    req_ep_d = epoch_q;
    req_pc_d = pc_q;
    if (redirect) pc_d = {redirect_pc[PC_W-1:2], 2'b00};
    else if (imem_req) pc_d = pc_inc(pc_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      epoch_q  <= 1'b0;
      req_ep_q <= 1'b0;
      outst_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      epoch_q  <= epoch_d;
      req_ep_q <= req_ep_d;
      outst_q  <= outst_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .count (count),
    .full  (full)
  );

  always_comb begin
    out_valid = (count != '0);
    out_instr = out_valid ? rdata.instr : '0;
    out_pc    = out_valid ? rdata.pc : '0;
  end

  a_no_resp_when_full: assert property (
    @(posedge clk) disable iff (!rst_n) !(imem_valid && full)
  );

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4: instruction queue entries; power of two, 2..8.
REQ-002 Parameter RESET_PC, default 8'h00: fetch address after reset.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 Port imem_req  output  1: fetch request to instruction memory this cycle.
REQ-006 Port imem_addr  output  8: byte address of the requested instruction.
REQ-007 Port imem_valid  input  1: response strobe, exactly one cycle after each imem_req.
REQ-008 Port imem_data  input  32: instruction word, qualified by imem_valid.
REQ-009 Port redirect  input  1: branch taken from the MEM stage (pcsrc); flushes the fetch stream.
REQ-010 Port redirect_pc  input  8: branch target byte address; bits [1:0] ignored and treated as 0.
REQ-011 Port stall  input  1: decode stage cannot accept; holds the queue head.
REQ-012 Port out_valid  output  1: queue head holds a valid instruction.
REQ-013 Port out_instr  output  32: queue-head instruction word; feeds the IF/ID instruction field.
REQ-014 Port out_pc  output  8: queue-head fetch address + 4; feeds the IF/ID PC field.

Function
REQ-015 The fetch PC shall advance by 4 per issued request, modulo 256 (8'hFC + 4 = 8'h00, no flag).
REQ-016 imem_req shall assert when (queue occupancy + outstanding request) < DEPTH and redirect is low.
REQ-017 Latency: request in cycle N, data in cycle N+1, enqueued at the end of N+1, out_valid high in N+2; no bypass.
REQ-018 Queue is FIFO; head dequeues at a rising edge when out_valid=1 and stall=0.
REQ-019 Enqueue and dequeue in the same cycle shall leave occupancy unchanged; this is legal when the queue is full.
REQ-020 The unit shall never enqueue into a full queue; REQ-016 guarantees this. An assertion shall flag any imem_valid when the queue is full.
REQ-021 out_instr and out_pc shall hold stable while out_valid=1 and stall=1.
REQ-022 On redirect=1, the next edge shall empty the queue, set PC to {redirect_pc[7:2],2'b00}, and toggle a 1-bit epoch.
REQ-023 Each request shall carry the epoch current at issue; a response whose epoch differs from the current epoch shall be discarded.
REQ-024 imem_req shall be low during a redirect cycle; the first request to the target shall issue the following cycle.
REQ-025 Redirect shall take priority over a same-cycle dequeue and enqueue; none of them takes effect.
REQ-026 Back-to-back redirects: the last one shall win; each redirect shall toggle the epoch.
REQ-027 out_valid shall be 0 whenever the queue is empty; out_instr and out_pc are don't-care then.

Reset
REQ-028 While rst_n=0: PC=RESET_PC, queue empty, outstanding=0, epoch=0, imem_req=0, out_valid=0, out_instr=0, out_pc=0.
REQ-029 Reset asserted mid-operation shall discard queue contents and any in-flight response immediately.
REQ-030 The first imem_req shall occur in the first cycle after rst_n deasserts, at RESET_PC.

Structure
REQ-031 A shared package shall hold PC_W=8, INSTR_W=32, PC_STEP=4, and the DEPTH default.
REQ-032 Queue storage shall be one sub-module, fetch_fifo (DEPTH x 40 bits: instr + pc), with wrap-around pointers and a count.
REQ-033 PC, epoch, outstanding flag and request logic shall reside in instr_fetch_unit.

Verification
REQ-034 Reset release, stall=0, imem returns word k = 32'h1000_0000+k -> out_pc 04,08,0C...; out_valid first high 2 cycles after first req; one instruction per cycle thereafter.
REQ-035 stall=1 held 10 cycles -> exactly DEPTH entries fetched, imem_req low once full; head stable; release -> in-order drain, no loss or duplication.
REQ-036 redirect=1 with redirect_pc=8'h43 while a request is in flight -> queue empties, stale response dropped, next imem_addr=8'h40, next out_pc=8'h44.
REQ-037 PC 8'hF8 free-running -> imem_addr F8, FC, 00, 04; out_pc FC, 00, 04, 08.
REQ-038 redirect in the same cycle as dequeue and enqueue -> occupancy 0 after the edge; redirects in two consecutive cycles (8'h20, 8'h80) -> only 8'h80 fetched.
REQ-039 rst_n pulsed low mid-stream with a full queue -> out_valid=0 asynchronously; restart at RESET_PC.
